// File: rtl/top_dma_core_engine_if.sv
`default_nettype none
// ============================================================================
// Module  : top_dma_core_engine_if
// Brief   : AXI4 master bundle (AR/R/AW/W/B) used by the DMA core engine.
// Revision: 1.0 - initial release
// ============================================================================
interface top_dma_core_engine_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic [7:0]              M_AXI_ARLEN;
    logic [2:0]              M_AXI_ARSIZE;
    logic [1:0]              M_AXI_ARBURST;
    logic                    M_AXI_ARVALID;
    logic                    M_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]              M_AXI_RRESP;
    logic                    M_AXI_RLAST;
    logic                    M_AXI_RVALID;
    logic                    M_AXI_RREADY;
    logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [7:0]              M_AXI_AWLEN;
    logic [2:0]              M_AXI_AWSIZE;
    logic [1:0]              M_AXI_AWBURST;
    logic                    M_AXI_AWVALID;
    logic                    M_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                    M_AXI_WLAST;
    logic                    M_AXI_WVALID;
    logic                    M_AXI_WREADY;
    logic [1:0]              M_AXI_BRESP;
    logic                    M_AXI_BVALID;
    logic                    M_AXI_BREADY;

    modport master (
        output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        output M_AXI_RREADY,
        output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY
    );

    modport slave (
        input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        input  M_AXI_RREADY,
        input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY
    );
endinterface
`default_nettype wire

// File: rtl/top_dma_core_engine.sv
`default_nettype none
// ============================================================================
// Module  : top_dma_core_engine
// Brief   : Memory-to-memory DMA; read burst into a local buffer, write it out,
//           repeat until the transfer length is consumed.
// Revision: 1.0 - initial release
// ============================================================================
module top_dma_core_engine #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_MAX_BURST_LEN    = 16
) (
    input  wire logic             M_AXI_ACLK,
    input  wire logic             M_AXI_ARESET,
    input  wire logic [31:0]      i_src_addr,
    input  wire logic [31:0]      i_dst_addr,
    input  wire logic [31:0]      i_trf_len,
    input  wire logic             i_dma_start,
    output logic                  o_dma_done,
    output logic                  o_dma_busy,
    output logic                  o_dma_error,
    top_dma_core_engine_if.master m_axi
);

    localparam int c_IDX_W = (C_MAX_BURST_LEN > 1) ? $clog2(C_MAX_BURST_LEN) : 1;
    localparam int c_AW    = C_M_AXI_ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        WR_RESP = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t                         r_state;
    logic [c_AW-1:0]                r_src;
    logic [c_AW-1:0]                r_dst;
    logic [31:0]                    r_remaining;
    logic [31:0]                    r_beats;
    logic [c_IDX_W-1:0]             r_idx;
    logic [C_M_AXI_DATA_WIDTH-1:0]  r_buf [0:C_MAX_BURST_LEN-1];

    logic [31:0]        w_len_words;
    logic [31:0]        w_src_room;
    logic [31:0]        w_dst_room;
    logic [31:0]        w_beats;
    logic [c_IDX_W-1:0] w_idx_nxt;
    logic               w_rd_beat;
    logic               w_unused_len_lsb;

    assign w_len_words      = {2'b00, i_trf_len[31:2]};
    assign w_unused_len_lsb = ^i_trf_len[1:0];
    assign w_idx_nxt        = r_idx + 1'b1;
    assign w_rd_beat        = (r_state == RD_DATA) && m_axi.M_AXI_RREADY && m_axi.M_AXI_RVALID;

    // Burst size: limited by remaining words, buffer depth and distance to the
    // next 4 KB page on both the source and destination side.
    always_comb begin
        w_src_room = (32'd4096 - {20'd0, r_src[11:0]}) >> 2;
        w_dst_room = (32'd4096 - {20'd0, r_dst[11:0]}) >> 2;
        w_beats    = r_remaining;
        if (32'(C_MAX_BURST_LEN) < w_beats) w_beats = 32'(C_MAX_BURST_LEN);
        if (w_src_room < w_beats)           w_beats = w_src_room;
        if (w_dst_room < w_beats)           w_beats = w_dst_room;
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (w_rd_beat) r_buf[r_idx] <= m_axi.M_AXI_RDATA;
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_state               <= IDLE;
            r_src                 <= '0;
            r_dst                 <= '0;
            r_remaining           <= '0;
            r_beats               <= '0;
            r_idx                 <= '0;
            o_dma_done            <= 1'b0;
            o_dma_busy            <= 1'b0;
            o_dma_error           <= 1'b0;
            m_axi.M_AXI_ARADDR    <= '0;
            m_axi.M_AXI_ARLEN     <= '0;
            m_axi.M_AXI_ARSIZE    <= '0;
            m_axi.M_AXI_ARBURST   <= '0;
            m_axi.M_AXI_ARVALID   <= 1'b0;
            m_axi.M_AXI_RREADY    <= 1'b0;
            m_axi.M_AXI_AWADDR    <= '0;
            m_axi.M_AXI_AWLEN     <= '0;
            m_axi.M_AXI_AWSIZE    <= '0;
            m_axi.M_AXI_AWBURST   <= '0;
            m_axi.M_AXI_AWVALID   <= 1'b0;
            m_axi.M_AXI_WDATA     <= '0;
            m_axi.M_AXI_WSTRB     <= '0;
            m_axi.M_AXI_WLAST     <= 1'b0;
            m_axi.M_AXI_WVALID    <= 1'b0;
            m_axi.M_AXI_BREADY    <= 1'b0;
        end else begin
            m_axi.M_AXI_ARSIZE  <= 3'b010;
            m_axi.M_AXI_AWSIZE  <= 3'b010;
            m_axi.M_AXI_ARBURST <= 2'b01;
            m_axi.M_AXI_AWBURST <= 2'b01;
            m_axi.M_AXI_WSTRB   <= '1;
            o_dma_done          <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (i_dma_start) begin
                        r_src       <= c_AW'(i_src_addr);
                        r_dst       <= c_AW'(i_dst_addr);
                        r_remaining <= w_len_words;
                        o_dma_error <= 1'b0;
                        o_dma_busy  <= 1'b1;
                        r_state     <= (w_len_words == 32'd0) ? DONE : RD_ADDR;
                    end
                end

                // First cycle loads the burst; the request then holds until ARREADY.
                RD_ADDR: begin
                    if (!m_axi.M_AXI_ARVALID) begin
                        m_axi.M_AXI_ARADDR  <= r_src;
                        m_axi.M_AXI_ARLEN   <= 8'(w_beats - 32'd1);
                        m_axi.M_AXI_ARVALID <= 1'b1;
                        r_beats             <= w_beats;
                    end else if (m_axi.M_AXI_ARREADY) begin
                        m_axi.M_AXI_ARVALID <= 1'b0;
                        m_axi.M_AXI_RREADY  <= 1'b1;
                        r_idx               <= '0;
                        r_state             <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (m_axi.M_AXI_RVALID) begin
                        if (m_axi.M_AXI_RRESP != 2'b00) o_dma_error <= 1'b1;
                        if (m_axi.M_AXI_RLAST) begin
                            m_axi.M_AXI_RREADY <= 1'b0;
                            r_idx              <= '0;
                            r_state <= (o_dma_error || (m_axi.M_AXI_RRESP != 2'b00)) ? DONE : WR_ADDR;
                        end else if (32'(r_idx) + 32'd1 < r_beats) begin
                            r_idx <= w_idx_nxt;
                        end
                    end
                end

                WR_ADDR: begin
                    if (!m_axi.M_AXI_AWVALID) begin
                        m_axi.M_AXI_AWADDR  <= r_dst;
                        m_axi.M_AXI_AWLEN   <= 8'(r_beats - 32'd1);
                        m_axi.M_AXI_AWVALID <= 1'b1;
                    end else if (m_axi.M_AXI_AWREADY) begin
                        m_axi.M_AXI_AWVALID <= 1'b0;
                        m_axi.M_AXI_WDATA   <= r_buf['0];
                        m_axi.M_AXI_WLAST   <= (r_beats == 32'd1);
                        m_axi.M_AXI_WVALID  <= 1'b1;
                        r_idx               <= '0;
                        r_state             <= WR_DATA;
                    end
                end

                WR_DATA: begin
                    if (m_axi.M_AXI_WREADY) begin
                        if (m_axi.M_AXI_WLAST) begin
                            m_axi.M_AXI_WVALID <= 1'b0;
                            m_axi.M_AXI_WLAST  <= 1'b0;
                            m_axi.M_AXI_BREADY <= 1'b1;
                            r_state            <= WR_RESP;
                        end else begin
                            r_idx             <= w_idx_nxt;
                            m_axi.M_AXI_WDATA <= r_buf[w_idx_nxt];
                            m_axi.M_AXI_WLAST <= (32'(w_idx_nxt) + 32'd1 == r_beats);
                        end
                    end
                end

                WR_RESP: begin
                    if (m_axi.M_AXI_BVALID) begin
                        m_axi.M_AXI_BREADY <= 1'b0;
                        if (m_axi.M_AXI_BRESP != 2'b00) begin
                            o_dma_error <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_src       <= r_src + c_AW'(r_beats << 2);
                            r_dst       <= r_dst + c_AW'(r_beats << 2);
                            r_remaining <= r_remaining - r_beats;
                            r_state     <= (r_remaining == r_beats) ? DONE : RD_ADDR;
                        end
                    end
                end

                DONE: begin
                    o_dma_done <= 1'b1;
                    o_dma_busy <= 1'b0;
                    r_state    <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/top_dma_core_engine.md
TOP_DMA_CORE_ENGINE -- requirements
Module: top_dma_core_engine

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI master address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, data width (only 32 supported).
REQ-003 SHALL have parameter C_MAX_BURST_LEN, default 16, max beats per burst; also internal buffer depth.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: M_AXI_ACLK input 1, M_AXI_ARESET input 1.
REQ-005 SHALL have i_src_addr input 32, source byte address, word aligned.
REQ-006 SHALL have i_dst_addr input 32, destination byte address, word aligned.
REQ-007 SHALL have i_trf_len input 32, transfer length in bytes; bits[1:0] ignored.
REQ-008 SHALL have i_dma_start input 1, one-cycle start pulse.
REQ-009 SHALL have o_dma_done output 1, one-cycle completion pulse.
REQ-010 SHALL have o_dma_busy output 1, high from the cycle after an accepted start until the cycle of o_dma_done.
REQ-011 SHALL have o_dma_error output 1, sticky error flag, cleared on the next accepted start.
REQ-012 SHALL have read address channel ports M_AXI_ARADDR out 32, ARLEN out 8, ARSIZE out 3, ARBURST out 2, ARVALID out 1 and ARREADY in 1.
REQ-013 SHALL have read data channel ports M_AXI_RDATA in 32, RRESP in 2, RLAST in 1, RVALID in 1 and RREADY out 1.
REQ-014 SHALL have write address channel ports M_AXI_AWADDR out 32, AWLEN out 8, AWSIZE out 3, AWBURST out 2, AWVALID out 1 and AWREADY in 1.
REQ-015 SHALL have write data channel ports M_AXI_WDATA out 32, WSTRB out 4, WLAST out 1, WVALID out 1 and WREADY in 1.
REQ-016 SHALL have write response channel ports M_AXI_BRESP in 2, BVALID in 1 and BREADY out 1.

Function
REQ-017 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE.
REQ-018 SHALL, in IDLE on i_dma_start, latch src, dst and word count (i_trf_len>>2), clear o_dma_error and go to RD_ADDR; if the word count is 0, go to DONE instead, with no AXI traffic.
REQ-019 SHALL ignore i_dma_start in every state except IDLE.
REQ-020 SHALL compute burst beats as min(remaining words, C_MAX_BURST_LEN, (4096-src[11:0])/4, (4096-dst[11:0])/4), so neither burst crosses a 4 KB boundary; ARLEN and AWLEN equal beats-1.
REQ-021 SHALL drive ARSIZE and AWSIZE = 3'b010, ARBURST and AWBURST = 2'b01 (INCR), and WSTRB = 4'hF.
REQ-022 SHALL, in RD_ADDR, hold ARVALID high with stable ARADDR and ARLEN until ARREADY; on handshake go to RD_DATA.
REQ-023 SHALL, in RD_DATA, hold RREADY high and store each RDATA beat in buffer[beat index]; on the beat with RLAST, go to WR_ADDR.
REQ-024 SHALL, in WR_ADDR, hold AWVALID high until AWREADY, then go to WR_DATA.
REQ-025 SHALL, in WR_DATA, present buffer[beat index] on WDATA with WVALID high and assert WLAST on the final beat; advance the beat only on WVALID and WREADY both high.
REQ-026 SHALL, in WR_RESP, hold BREADY high until BVALID; then add beats*4 to src and dst, subtract beats from remaining, and go to RD_ADDR, or to DONE when remaining reaches 0.
REQ-027 SHALL treat RRESP or BRESP not equal to 0 as an error: set o_dma_error, finish the current burst's handshakes, then go to DONE.
REQ-028 SHALL, in DONE, pulse o_dma_done for one cycle and return to IDLE.
REQ-029 SHALL never assert ARVALID, AWVALID, WVALID, RREADY or BREADY outside their own states.

Reset
REQ-030 SHALL, while M_AXI_ARESET is high, immediately force the FSM to IDLE and all outputs to 0, including mid-burst; buffer contents are don't-care.

Verification
REQ-031 Len=64, src=0x1000, dst=0x2000, zero-wait slave -> one 16-beat read and one 16-beat write, ARLEN=AWLEN=15, dst words equal src words, done pulse, error=0.
REQ-032 Len=0x50 (20 words) -> bursts of 16 then 4 beats, ARADDR 0x1000 then 0x1040, exactly one done pulse.
REQ-033 src=0x1FF8, len=32 -> first burst 2 beats (ARLEN=1), then 6 beats at 0x2000; no burst crosses the 4 KB boundary.
REQ-034 Random ARREADY, RVALID, AWREADY and WREADY stalls -> data intact; AXI payload signals stable while VALID is high and READY is low.
REQ-035 BRESP=2'b10 on the first burst of a 2-burst transfer -> o_dma_error=1, no second AR, done pulse; a new start clears the error.
REQ-036 Reset asserted in WR_DATA, then start pulsed while busy -> all VALID signals 0 within the same cycle; the start while busy has no effect.
